// File: rtl/ram_burst_pkg.sv
// Shared types and default widths for the RAM burst master.
// Holds the FSM state enum and address/data typedefs.
package ram_burst_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/ram_burst_if.sv
// Bundle of command, write-stream, read-stream and RAM-side signals.
// master: the burst master; slave: command source, data ends and RAM.
interface ram_burst_if
  import ram_burst_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;

  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;

  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              done;

  logic              ram_read;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_out;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wdata_valid, wdata, ram_out,
    output cmd_ready, wdata_ready,
    output rdata_valid, rdata, done,
    output ram_read, ram_write, ram_addr, ram_data
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wdata_valid, wdata, ram_out,
    input  cmd_ready, wdata_ready,
    input  rdata_valid, rdata, done,
    input  ram_read, ram_write, ram_addr, ram_data
  );

endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port RAM with 1-cycle read latency.
// Ports: clk, rst (sync, active-low), bus (ram_burst_if.master).
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic        clk,
  input  logic        rst,
  ram_burst_if.master bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              done_q, done_d;
  logic              rvalid_q;
  logic [DATA_W-1:0] wdata_w;

  assign wdata_w = bus.wdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      done_q   <= done_d;
      rvalid_q <= bus.ram_read;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    done_d          = 1'b0;
    bus.cmd_ready   = 1'b0;
    bus.wdata_ready = 1'b0;
    bus.ram_read    = 1'b0;
    bus.ram_write   = 1'b0;
    bus.ram_addr    = '0;
    bus.ram_data    = '0;
    unique case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          rem_d   = bus.cmd_len;
          state_d = bus.cmd_write ? WR : RD;
        end
      end
      WR: begin
        bus.wdata_ready = 1'b1;
        if (bus.wdata_valid) begin
          bus.ram_write = 1'b1;
          bus.ram_addr  = addr_q;
          bus.ram_data  = wdata_w;
          addr_d        = addr_q + ADDR_W'(1);
          if (rem_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rem_d = rem_q - ADDR_W'(1);
          end
        end
      end
      RD: begin
        bus.ram_read = 1'b1;
        bus.ram_addr = addr_q;
        addr_d       = addr_q + ADDR_W'(1);
        if (rem_q == '0) begin
          state_d = DRAIN;
        end else begin
          rem_d = rem_q - ADDR_W'(1);
        end
      end
      DRAIN: begin
        // Last read returns here; done lands as we re-enter IDLE.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.done        = done_q;
  assign bus.rdata_valid = rvalid_q;
  assign bus.rdata       = bus.ram_out;

  a_strobe_excl: assert property (
    @(posedge clk) disable iff (!rst)
    !(bus.ram_read && bus.ram_write));

  a_done_pulse: assert property (
    @(posedge clk) disable iff (!rst)
    bus.done |=> !bus.done);

  // Skip the first cycle after reset: its previous read was discarded.
  a_rvalid_lat: assert property (
    @(posedge clk) disable iff (!rst)
    $past(rst) |-> (bus.rdata_valid == $past(bus.ram_read)));

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural 256x16 RAM.
// Monitors strobes on the falling edge; inputs change 1ns after rise.
module tb_ram_burst_master;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   cyc_n;

  ram_burst_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  ram_burst_master #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [256];
  logic [15:0] ram_q;
  logic        ram_rst;

  assign ram_rst     = ~rst;
  assign bus.ram_out = ram_q;

  always @(posedge clk) begin
    if (ram_rst) begin
      ram_q <= '0;
    end else if (bus.ram_read) begin
      ram_q <= mem[bus.ram_addr];
    end
    if (!ram_rst && bus.ram_write) begin
      mem[bus.ram_addr] <= bus.ram_data;
    end
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [23:0] wq[$];
  int          wr_cyc[$];
  logic [7:0]  raq[$];
  int          rd_cyc[$];
  logic [15:0] rq[$];
  int          rv_cyc[$];
  int          done_cyc[$];
  int          overlap;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.ram_write) begin
        wq.push_back({bus.ram_addr, bus.ram_data});
        wr_cyc.push_back(cyc_n);
      end
      if (bus.ram_read) begin
        raq.push_back(bus.ram_addr);
        rd_cyc.push_back(cyc_n);
      end
      if (bus.rdata_valid) begin
        rq.push_back(bus.rdata);
        rv_cyc.push_back(cyc_n);
      end
      if (bus.done) done_cyc.push_back(cyc_n);
      if (bus.ram_read && bus.ram_write) overlap++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wq.delete(); wr_cyc.delete();
    raq.delete(); rd_cyc.delete();
    rq.delete(); rv_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic send_cmd(input logic w, input logic [7:0] a,
                          input logic [7:0] l);
    logic ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      cyc();
    end
    bus.cmd_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL cmd_timeout: cmd_ready=0 required=1");
    end
  endtask

  task automatic write_beat(input logic [15:0] d, input int stall);
    logic ok;
    ok = 1'b0;
    bus.wdata_valid = 1'b0;
    repeat (stall) cyc();
    bus.wdata_valid = 1'b1;
    bus.wdata       = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = bus.wdata_ready;
      cyc();
    end
    bus.wdata_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wdata_timeout: wdata_ready=0 required=1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready);
    end
    checks++;
    if ({bus.wdata_ready, bus.ram_read, bus.ram_write} !== 3'b000) begin
      errors++;
      $display("FAIL rst_strobes: got %b%b%b want 000",
               bus.wdata_ready, bus.ram_read, bus.ram_write);
    end
    checks++;
    if ({bus.ram_addr, bus.ram_data} !== 24'h0) begin
      errors++;
      $display("FAIL rst_bus: addr=%h data=%h want 0",
               bus.ram_addr, bus.ram_data);
    end
    checks++;
    if ({bus.rdata_valid, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL rst_regs: rv=%b done=%b want 00",
               bus.rdata_valid, bus.done);
    end
    cyc();
  endtask

  task automatic test_single();
    clear_logs();
    send_cmd(1'b1, 8'h10, 8'h00);
    write_beat(16'hBEEF, 0);
    repeat (3) cyc();
    checks++;
    if (wq.size() != 1 || wq[0] !== 24'h10BEEF) begin
      errors++;
      $display("FAIL single_wr: n=%0d first=%h want 1 10beef",
               wq.size(), wq.size() ? wq[0] : 24'h0);
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != wr_cyc[0] + 1) begin
      errors++;
      $display("FAIL single_wr_done: n=%0d want 1 at wr+1",
               done_cyc.size());
    end
    clear_logs();
    send_cmd(1'b0, 8'h10, 8'h00);
    repeat (4) cyc();
    checks++;
    if (rq.size() != 1 || rq[0] !== 16'hBEEF) begin
      errors++;
      $display("FAIL single_rd: n=%0d data=%h want 1 beef",
               rq.size(), rq.size() ? rq[0] : 16'h0);
    end
    checks++;
    if (rd_cyc.size() != 1 || rv_cyc.size() != 1 ||
        rv_cyc[0] != rd_cyc[0] + 1) begin
      errors++;
      $display("FAIL single_lat: rd=%0d rv=%0d want rv=rd+1",
               rd_cyc.size(), rv_cyc.size());
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != rd_cyc[0] + 2) begin
      errors++;
      $display("FAIL single_rd_done: n=%0d want 1 at rd+2",
               done_cyc.size());
    end
  endtask

  task automatic test_wrap();
    logic [23:0] ew [4];
    logic [15:0] er [4];
    int bad;
    ew = '{24'hFE1111, 24'hFF2222, 24'h003333, 24'h014444};
    er = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    clear_logs();
    send_cmd(1'b1, 8'hFE, 8'h03);
    for (int i = 0; i < 4; i++) write_beat(er[i], 0);
    repeat (3) cyc();
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (i >= wq.size() || wq[i] !== ew[i]) bad++;
    checks++;
    if (wq.size() != 4 || bad != 0) begin
      errors++;
      $display("FAIL wrap_wr: n=%0d bad=%0d want 4 0", wq.size(), bad);
    end
    clear_logs();
    send_cmd(1'b0, 8'hFE, 8'h03);
    repeat (8) cyc();
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (i >= rq.size() || rq[i] !== er[i]) bad++;
    checks++;
    if (rq.size() != 4 || bad != 0) begin
      errors++;
      $display("FAIL wrap_rd: n=%0d bad=%0d want 4 0", rq.size(), bad);
    end
    bad = 0;
    for (int i = 1; i < rv_cyc.size(); i++)
      if (rv_cyc[i] != rv_cyc[i-1] + 1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wrap_b2b: gaps=%0d want 0", bad);
    end
    checks++;
    if (done_cyc.size() != 1) begin
      errors++;
      $display("FAIL wrap_done: n=%0d want 1", done_cyc.size());
    end
  endtask

  task automatic test_write_stall();
    clear_logs();
    bus.wdata_valid = 1'b1;
    bus.wdata       = 16'hDEAD;
    @(negedge clk);
    checks++;
    if (bus.wdata_ready !== 1'b0 || bus.ram_write !== 1'b0) begin
      errors++;
      $display("FAIL early_wdata: ready=%b write=%b want 0 0",
               bus.wdata_ready, bus.ram_write);
    end
    cyc();
    bus.wdata_valid = 1'b0;
    send_cmd(1'b1, 8'h40, 8'h02);
    write_beat(16'hA001, 0);
    write_beat(16'hA002, 3);
    write_beat(16'hA003, 3);
    repeat (3) cyc();
    checks++;
    if (wq.size() != 3 || wq[0] !== 24'h40A001 ||
        wq[1] !== 24'h41A002 || wq[2] !== 24'h42A003) begin
      errors++;
      $display("FAIL stall_wr: n=%0d want 3 at 40..42", wq.size());
    end
    checks++;
    if (wr_cyc.size() != 3 || wr_cyc[1] != wr_cyc[0] + 4 ||
        wr_cyc[2] != wr_cyc[1] + 4) begin
      errors++;
      $display("FAIL stall_gap: n=%0d want 3 beats 4 apart",
               wr_cyc.size());
    end
    checks++;
    if (done_cyc.size() != 1 || wr_cyc.size() != 3 ||
        done_cyc[0] != wr_cyc[2] + 1) begin
      errors++;
      $display("FAIL stall_done: n=%0d want 1 after beat 3",
               done_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ea [6];
    int early;
    logic seen;
    int bad;
    ea = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hFE, 8'hFF};
    clear_logs();
    send_cmd(1'b0, 8'h10, 8'h03);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'hFE;
    bus.cmd_len   = 8'h01;
    early = 0;
    seen  = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_done: got %b want 1", bus.cmd_ready);
        end
      end else if (bus.cmd_ready) begin
        early++;
      end
      cyc();
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (!seen || early != 0) begin
      errors++;
      $display("FAIL b2b_busy: done_seen=%b early_ready=%0d want 1 0",
               seen, early);
    end
    repeat (6) cyc();
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (i >= raq.size() || raq[i] !== ea[i]) bad++;
    checks++;
    if (raq.size() != 6 || bad != 0) begin
      errors++;
      $display("FAIL b2b_addrs: n=%0d bad=%0d want 6 0",
               raq.size(), bad);
    end
    checks++;
    if (done_cyc.size() != 2 || rq.size() != 6) begin
      errors++;
      $display("FAIL b2b_counts: done=%0d beats=%0d want 2 6",
               done_cyc.size(), rq.size());
    end
  endtask

  task automatic test_reset_mid();
    int nrq;
    int nra;
    clear_logs();
    send_cmd(1'b0, 8'h20, 8'h07);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.ram_read, bus.rdata_valid, bus.cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL midrst_state: rd=%b rv=%b rdy=%b want 0 0 1",
               bus.ram_read, bus.rdata_valid, bus.cmd_ready);
    end
    nrq = rq.size();
    nra = raq.size();
    repeat (12) cyc();
    checks++;
    if (done_cyc.size() != 0) begin
      errors++;
      $display("FAIL midrst_done: n=%0d want 0", done_cyc.size());
    end
    checks++;
    if (rq.size() != nrq || raq.size() != nra || nra != 2) begin
      errors++;
      $display("FAIL midrst_quiet: beats=%0d/%0d reads=%0d/%0d want 2",
               rq.size(), nrq, raq.size(), nra);
    end
  endtask

  task automatic test_full();
    logic [7:0]  a;
    logic [15:0] exp;
    int bad;
    clear_logs();
    overlap = 0;
    send_cmd(1'b1, 8'h37, 8'hFF);
    for (int i = 0; i < 256; i++) begin
      a = 8'(8'h37 + i);
      write_beat({8'h00, a} ^ 16'hA5A5, 0);
    end
    repeat (3) cyc();
    checks++;
    if (wq.size() != 256 || done_cyc.size() != 1) begin
      errors++;
      $display("FAIL full_wr: n=%0d done=%0d want 256 1",
               wq.size(), done_cyc.size());
    end
    clear_logs();
    send_cmd(1'b0, 8'h37, 8'hFF);
    repeat (262) cyc();
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      a   = 8'(8'h37 + i);
      exp = {8'h00, a} ^ 16'hA5A5;
      if (i >= rq.size() || rq[i] !== exp) bad++;
    end
    checks++;
    if (rq.size() != 256 || bad != 0) begin
      errors++;
      $display("FAIL full_rd: n=%0d bad=%0d want 256 0", rq.size(), bad);
    end
    checks++;
    if (raq.size() != 256 || raq[255] !== 8'h36) begin
      errors++;
      $display("FAIL full_last_addr: n=%0d want 256 ending 36",
               raq.size());
    end
    checks++;
    if (overlap != 0 || done_cyc.size() != 1) begin
      errors++;
      $display("FAIL full_misc: overlap=%0d done=%0d want 0 1",
               overlap, done_cyc.size());
    end
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    cyc_n           = 0;
    overlap         = 0;
    rst             = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    test_reset();
    test_single();
    test_wrap();
    test_write_stall();
    test_back_to_back();
    test_reset_mid();
    test_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
